// File: rtl/m_serial_sub.sv
// Bit-serial subtractor/comparator: computes A - B one bit per clock, LSB first,
// as A + ~B + 1, and registers the difference plus zero/unsigned/signed-less-than flags.
module m_serial_sub #(
    parameter int WIDTH = 32
) (
    input  logic             w_clk,
    input  logic             w_rst_n,
    input  logic             w_start,
    input  logic [WIDTH-1:0] w_a,
    input  logic [WIDTH-1:0] w_b,
    output logic             w_busy,
    output logic             w_done,
    output logic [WIDTH-1:0] w_diff,
    output logic             w_zero,
    output logic             w_ltu,
    output logic             w_lts
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             c_q, c_d;
    logic             zacc_q, zacc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             zero_q, zero_d;
    logic             ltu_q, ltu_d;
    logic             lts_q, lts_d;

    logic sum_bit;
    logic carry_next;
    logic last_step;

    assign sum_bit    = a_q[0] ^ b_q[0] ^ c_q;
    assign carry_next = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);
    assign last_step  = (cnt_q == LAST_STEP);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        zacc_d  = zacc_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        zero_d  = zero_q;
        ltu_d   = ltu_q;
        lts_d   = lts_q;

        case (state_q)
            S_SHIFT: begin
                a_d    = {sum_bit, a_q[WIDTH-1:1]};
                b_d    = {1'b0, b_q[WIDTH-1:1]};
                c_d    = carry_next;
                zacc_d = zacc_q | sum_bit;
                cnt_d  = cnt_q + CW'(1);
                if (last_step) begin
                    // Overflow is carry-into-MSB xor carry-out; signed LT is sign xor overflow.
                    state_d = S_DONE;
                    diff_d  = {sum_bit, a_q[WIDTH-1:1]};
                    zero_d  = ~(zacc_q | sum_bit);
                    ltu_d   = ~carry_next;
                    lts_d   = sum_bit ^ (c_q ^ carry_next);
                end
            end
            default: begin
                // IDLE and DONE both accept a new operation.
                state_d = S_IDLE;
                if (w_start) begin
                    state_d = S_SHIFT;
                    a_d     = w_a;
                    b_d     = ~w_b;
                    c_d     = 1'b1;
                    zacc_d  = 1'b0;
                    cnt_d   = '0;
                end
            end
        endcase
    end

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            zacc_q  <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            zero_q  <= 1'b0;
            ltu_q   <= 1'b0;
            lts_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            zacc_q  <= zacc_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            zero_q  <= zero_d;
            ltu_q   <= ltu_d;
            lts_q   <= lts_d;
        end
    end

    assign w_busy = (state_q == S_SHIFT);
    assign w_done = (state_q == S_DONE);
    assign w_diff = diff_q;
    assign w_zero = zero_q;
    assign w_ltu  = ltu_q;
    assign w_lts  = lts_q;
endmodule

// File: tb/tb_m_serial_sub.sv
// Bench for m_serial_sub: directed vector table, back-to-back, reset abort and
// random regression on 32-bit and 8-bit instances, checked through result queues.
module tb_m_serial_sub;
    typedef struct packed {
        logic [31:0] diff;
        logic        zero;
        logic        ltu;
        logic        lts;
    } res_t;

    typedef struct packed {
        logic [7:0] diff;
        logic       zero;
        logic       ltu;
        logic       lts;
    } res8_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        res_t        exp;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        start32, start8;
    logic [31:0] a32, b32;
    logic [7:0]  a8, b8;
    logic        busy32, done32, zero32, ltu32, lts32;
    logic [31:0] diff32;
    logic        busy8, done8, zero8, ltu8, lts8;
    logic [7:0]  diff8;

    int checks = 0;
    int errors = 0;

    res_t  q32[$];
    res8_t q8[$];

    m_serial_sub #(.WIDTH(32)) dut32 (
        .w_clk(clk), .w_rst_n(rst_n), .w_start(start32), .w_a(a32), .w_b(b32),
        .w_busy(busy32), .w_done(done32), .w_diff(diff32),
        .w_zero(zero32), .w_ltu(ltu32), .w_lts(lts32)
    );

    m_serial_sub #(.WIDTH(8)) dut8 (
        .w_clk(clk), .w_rst_n(rst_n), .w_start(start8), .w_a(a8), .w_b(b8),
        .w_busy(busy8), .w_done(done8), .w_diff(diff8),
        .w_zero(zero8), .w_ltu(ltu8), .w_lts(lts8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic res_t model32(input logic [31:0] a, input logic [31:0] b);
        res_t r;
        r.diff = a - b;
        r.zero = (a == b);
        r.ltu  = (a < b);
        r.lts  = ($signed(a) < $signed(b));
        return r;
    endfunction

    function automatic res8_t model8(input logic [7:0] a, input logic [7:0] b);
        res8_t r;
        r.diff = a - b;
        r.zero = (a == b);
        r.ltu  = (a < b);
        r.lts  = ($signed(a) < $signed(b));
        return r;
    endfunction

    // Scoreboards: every done pulse pops and compares the oldest expected result.
    always @(negedge clk) begin
        if (done32) begin
            checks++;
            if (q32.size() == 0) begin
                errors++;
                $display("FAIL done32_unexpected diff=%h", diff32);
            end else begin
                res_t e;
                e = q32.pop_front();
                if ({diff32, zero32, ltu32, lts32} !== e) begin
                    errors++;
                    $display("FAIL result32 got diff=%h z=%b ltu=%b lts=%b want diff=%h z=%b ltu=%b lts=%b",
                             diff32, zero32, ltu32, lts32, e.diff, e.zero, e.ltu, e.lts);
                end else begin
                    $display("result32 diff=%h z=%b ltu=%b lts=%b ok", diff32, zero32, ltu32, lts32);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (done8) begin
            checks++;
            if (q8.size() == 0) begin
                errors++;
                $display("FAIL done8_unexpected diff=%h", diff8);
            end else begin
                res8_t e;
                e = q8.pop_front();
                if ({diff8, zero8, ltu8, lts8} !== e) begin
                    errors++;
                    $display("FAIL result8 got diff=%h z=%b ltu=%b lts=%b want diff=%h z=%b ltu=%b lts=%b",
                             diff8, zero8, ltu8, lts8, e.diff, e.zero, e.ltu, e.lts);
                end
            end
        end
    end

    // Single start pulse with exact busy/done timing checks.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input res_t exp);
        int bad;
        @(negedge clk);
        a32 = a; b32 = b; start32 = 1'b1;
        q32.push_back(exp);
        @(negedge clk);
        start32 = 1'b0;
        a32 = $urandom; b32 = $urandom;
        bad = 0;
        for (int k = 0; k < 32; k++) begin
            if (!(busy32 === 1'b1 && done32 === 1'b0)) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL busy_window a=%h b=%h got %0d bad cycles want 0", a, b, bad);
        end
        checks++;
        if (!(done32 === 1'b1 && busy32 === 1'b0)) begin
            errors++;
            $display("FAIL done_latency got done=%b busy=%b want done=1 busy=0", done32, busy32);
        end
        @(negedge clk);
        checks++;
        if (done32 !== 1'b0) begin
            errors++;
            $display("FAIL done_width got done=%b want 0", done32);
        end
    endtask

    task automatic back_to_back(input int n);
        res_t e, prev;
        logic have_prev;
        have_prev = 1'b0;
        @(negedge clk);
        start32 = 1'b1;
        for (int op = 0; op < n; op++) begin
            a32 = $urandom; b32 = $urandom;
            e = model32(a32, b32);
            q32.push_back(e);
            @(negedge clk);
            for (int k = 0; k < 32; k++) begin
                if (k == 16 && have_prev) begin
                    checks++;
                    if (diff32 !== prev.diff) begin
                        errors++;
                        $display("FAIL hold_in_shift got %h want %h", diff32, prev.diff);
                    end
                end
                a32 = $urandom; b32 = $urandom;
                @(negedge clk);
            end
            checks++;
            if (done32 !== 1'b1) begin
                errors++;
                $display("FAIL b2b_done op=%0d got %b want 1", op, done32);
            end
            prev = e;
            have_prev = 1'b1;
        end
        start32 = 1'b0;
        @(negedge clk);
        checks++;
        if (!(done32 === 1'b0 && busy32 === 1'b0)) begin
            errors++;
            $display("FAIL b2b_idle got done=%b busy=%b want 0 0", done32, busy32);
        end
    endtask

    task automatic random32(input int n);
        int t;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            a32 = $urandom;
            b32 = (i % 8 == 0) ? a32 : ((i % 8 == 1) ? 32'h8000_0000 : 32'($urandom));
            q32.push_back(model32(a32, b32));
            start32 = 1'b1;
            @(negedge clk);
            start32 = 1'b0;
            t = 0;
            while (done32 !== 1'b1 && t < 40) begin
                @(negedge clk);
                t++;
            end
            if (done32 !== 1'b1) begin
                checks++; errors++;
                $display("FAIL timeout32 op=%0d", i);
            end
        end
    endtask

    task automatic random8(input int n);
        int t;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            a8 = 8'($urandom);
            b8 = (i % 8 == 0) ? a8 : 8'($urandom);
            q8.push_back(model8(a8, b8));
            start8 = 1'b1;
            @(negedge clk);
            start8 = 1'b0;
            t = 0;
            while (done8 !== 1'b1 && t < 16) begin
                @(negedge clk);
                t++;
            end
            if (done8 !== 1'b1) begin
                checks++; errors++;
                $display("FAIL timeout8 op=%0d", i);
            end
        end
    endtask

    vec_t vecs[8];

    initial begin
        int dones;
        vecs[0] = '{32'd7,          32'd6,          '{32'h0000_0001, 1'b0, 1'b0, 1'b0}};
        vecs[1] = '{32'd6,          32'd7,          '{32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1}};
        vecs[2] = '{32'd5,          32'd5,          '{32'h0000_0000, 1'b1, 1'b0, 1'b0}};
        vecs[3] = '{32'h8000_0000,  32'd1,          '{32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1}};
        vecs[4] = '{32'd1,          32'hFFFF_FFFF,  '{32'h0000_0002, 1'b0, 1'b1, 1'b0}};
        vecs[5] = '{32'd0,          32'd0,          '{32'h0000_0000, 1'b1, 1'b0, 1'b0}};
        vecs[6] = '{32'h7FFF_FFFF,  32'h8000_0000,  '{32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0}};
        vecs[7] = '{32'd9,          32'd4,          '{32'h0000_0005, 1'b0, 1'b0, 1'b0}};

        rst_n = 1'b0; start32 = 1'b0; start8 = 1'b0;
        a32 = '0; b32 = '0; a8 = '0; b8 = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy32, done32, diff32, zero32, ltu32, lts32} !== '0) begin
            errors++;
            $display("FAIL reset_state got busy=%b done=%b diff=%h z=%b ltu=%b lts=%b want all 0",
                     busy32, done32, diff32, zero32, ltu32, lts32);
        end
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) run_op(vecs[i].a, vecs[i].b, vecs[i].exp);

        back_to_back(4);

        // Abort an operation with reset partway through SHIFT; the last result (diff=5) must clear.
        run_op(32'd9, 32'd4, model32(32'd9, 32'd4));
        @(negedge clk);
        a32 = 32'd3; b32 = 32'd8; start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy32, done32, diff32, zero32, ltu32, lts32} !== '0) begin
            errors++;
            $display("FAIL reset_abort got busy=%b done=%b diff=%h z=%b ltu=%b lts=%b want all 0",
                     busy32, done32, diff32, zero32, ltu32, lts32);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (done32 === 1'b1) dones++;
        end
        checks++;
        if (dones != 0) begin
            errors++;
            $display("FAIL abort_no_done got %0d pulses want 0", dones);
        end
        run_op(32'd3, 32'd8, '{32'hFFFF_FFFB, 1'b0, 1'b1, 1'b1});

        fork
            random32(1000);
            random8(1000);
        join

        repeat (3) @(negedge clk);
        checks++;
        if (q32.size() != 0 || q8.size() != 0) begin
            errors++;
            $display("FAIL drain got q32=%0d q8=%0d want 0 0", q32.size(), q8.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
